// File: rtl/adder_sub_4bit_serial.sv
`default_nettype none
// ============================================================================
// Module   : adder_sub_4bit_serial
// Purpose  : Bit-serial adder/subtractor. Processes one bit per clock through a
//            single full-adder slice and a stored carry (start/done handshake).
// Revision : 1.0 - initial release
// ============================================================================
module adder_sub_4bit_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Ci,
    output logic [WIDTH-1:0] S,
    output logic             Co,
    output logic             busy,
    output logic             done
);

    localparam int         c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_res_sr;
    logic               r_c;
    logic [c_CNT_W-1:0] r_cnt;

    logic               w_accept;
    logic               w_last;
    logic               w_sum;
    logic               w_carry;
    logic [WIDTH-1:0]   w_res_nxt;

    assign w_accept  = start && ((r_state == c_IDLE) || (r_state == c_DONE));
    assign w_last    = (r_cnt == c_LAST);
    assign w_sum     = r_a_sr[0] ^ r_b_sr[0] ^ r_c;
    assign w_carry   = (r_a_sr[0] & r_b_sr[0]) | (r_a_sr[0] & r_c) | (r_b_sr[0] & r_c);
    assign w_res_nxt = {w_sum, r_res_sr[WIDTH-1:1]};

    // busy/done are registered from next-state so no input reaches an output combinationally
    always_comb begin
        w_state_nxt = r_state;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_nxt = c_RUN;
                    w_busy_nxt  = 1'b1;
                end
            end
            c_RUN: begin
                if (w_last) begin
                    w_state_nxt = c_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_busy_nxt  = 1'b1;
                end
            end
            c_DONE: begin
                if (start) begin
                    w_state_nxt = c_RUN;
                    w_busy_nxt  = 1'b1;
                end else begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            busy    <= w_busy_nxt;
            done    <= w_done_nxt;
        end
    end

    // Subtraction is A + ~B + 1: B is inverted at capture and the +1 rides in as the initial carry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_res_sr <= '0;
            r_c      <= 1'b0;
            r_cnt    <= '0;
            S        <= '0;
            Co       <= 1'b0;
        end else if (w_accept) begin
            r_a_sr   <= A;
            r_b_sr   <= Ci ? ~B : B;
            r_res_sr <= '0;
            r_c      <= Ci;
            r_cnt    <= '0;
        end else if (r_state == c_RUN) begin
            r_a_sr   <= r_a_sr >> 1;
            r_b_sr   <= r_b_sr >> 1;
            r_res_sr <= w_res_nxt;
            r_c      <= w_carry;
            r_cnt    <= r_cnt + c_CNT_W'(1);
            if (w_last) begin
                S  <= w_res_nxt;
                Co <= w_carry;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adder_sub_4bit_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_sub_4bit_serial
// Purpose  : Self-checking bench for adder_sub_4bit_serial against an
//            arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_sub_4bit_serial;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] A = '0;
    logic [3:0] B = '0;
    logic       Ci = 1'b0;
    logic [3:0] S;
    logic       Co;
    logic       busy;
    logic       done;

    int err_cnt = 0;
    int chk_cnt = 0;

    adder_sub_4bit_serial #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Ci    (Ci),
        .S     (S),
        .Co    (Co),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] ref_op(input logic [3:0] a, input logic [3:0] b, input logic ci);
        int unsigned bv;
        int unsigned total;
        bv    = ci ? (15 - int'(b)) : int'(b);
        total = int'(a) + bv + (ci ? 1 : 0);
        return 5'(total);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one start and scrambles the operand inputs while the operation runs.
    // Returns cycles from the accept edge to done (-1 on timeout) and busy cycle count.
    task automatic do_op(input logic [3:0] a, input logic [3:0] b, input logic ci,
                         output int lat, output int bcnt, output logic ovl);
        int i;
        A = a; B = b; Ci = ci; start = 1'b1;
        step();
        start = 1'b0;
        lat = -1; bcnt = 0; ovl = 1'b0; i = 0;
        while (i < 20 && lat < 0) begin
            if (busy && done) ovl = 1'b1;
            if (done) begin
                lat = i;
            end else begin
                if (busy) bcnt++;
                A = 4'($urandom); B = 4'($urandom); Ci = 1'($urandom);
                step();
                i++;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; A = 4'hF; B = 4'h1; Ci = 1'b0;
        step();
        step();
        chk_cnt++;
        if ({S, Co, busy, done} !== 7'b0) begin
            err_cnt++;
            $display("FAIL reset_outputs got S=%b Co=%b busy=%b done=%b exp all zero", S, Co, busy, done);
        end
        rst = 1'b0; start = 1'b0;
        step();
        chk_cnt++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            err_cnt++;
            $display("FAIL reset_idle got busy=%b done=%b exp 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        logic [3:0] va [4] = '{4'b0110, 4'b0110, 4'b0110, 4'b0000};
        logic [3:0] vb [4] = '{4'b1001, 4'b1001, 4'b0110, 4'b0000};
        logic       vc [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        logic [4:0] vexp [4] = '{5'b0_1111, 5'b0_1101, 5'b1_0000, 5'b1_0000};
        int lat, bcnt;
        logic ovl;
        for (int k = 0; k < 4; k++) begin
            do_op(va[k], vb[k], vc[k], lat, bcnt, ovl);
            chk_cnt++;
            if ({Co, S} !== vexp[k] || lat != 4 || bcnt != 4 || ovl) begin
                err_cnt++;
                $display("FAIL directed_%0d got Co=%b S=%b lat=%0d busy=%0d ovl=%b exp Co=%b S=%b lat=4 busy=4 ovl=0",
                         k, Co, S, lat, bcnt, ovl, vexp[k][4], vexp[k][3:0]);
            end
            step();
            step();
            step();
            chk_cnt++;
            if ({Co, S} !== vexp[k] || done !== 1'b0 || busy !== 1'b0) begin
                err_cnt++;
                $display("FAIL hold_%0d got Co=%b S=%b done=%b busy=%b exp Co=%b S=%b done=0 busy=0",
                         k, Co, S, done, busy, vexp[k][4], vexp[k][3:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int i;
        int lat;
        A = 4'b0110; B = 4'b1111; Ci = 1'b0; start = 1'b1;
        step();
        i = 0; lat = -1;
        while (i < 20 && lat < 0) begin
            if (done) begin
                lat = i;
            end else begin
                start = 1'($urandom); A = 4'($urandom); B = 4'($urandom); Ci = 1'($urandom);
                step();
                i++;
            end
        end
        chk_cnt++;
        if (lat != 4 || {Co, S} !== 5'b1_0101) begin
            err_cnt++;
            $display("FAIL b2b_first got lat=%0d Co=%b S=%b exp lat=4 Co=1 S=0101", lat, Co, S);
        end
        A = 4'b0000; B = 4'b1001; Ci = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        i = 1; lat = -1;
        while (i < 20 && lat < 0) begin
            if (done) begin
                lat = i;
            end else begin
                step();
                i++;
            end
        end
        chk_cnt++;
        if (lat != 5 || {Co, S} !== 5'b0_0111) begin
            err_cnt++;
            $display("FAIL b2b_second got gap=%0d Co=%b S=%b exp gap=5 Co=0 S=0111", lat, Co, S);
        end
        step();
    endtask

    task automatic test_reset_mid_run();
        int lat, bcnt;
        logic ovl;
        logic seen_done;
        logic [4:0] exp;
        do_op(4'b0110, 4'b1001, 1'b0, lat, bcnt, ovl);
        step();
        A = 4'b0011; B = 4'b0101; Ci = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_cnt++;
        if ({S, Co, busy, done} !== 7'b0) begin
            err_cnt++;
            $display("FAIL midrun_reset got S=%b Co=%b busy=%b done=%b exp all zero", S, Co, busy, done);
        end
        seen_done = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (done || busy) seen_done = 1'b1;
            step();
        end
        chk_cnt++;
        if (seen_done !== 1'b0) begin
            err_cnt++;
            $display("FAIL midrun_no_done got activity=%b exp 0", seen_done);
        end
        exp = ref_op(4'b1011, 4'b0100, 1'b1);
        do_op(4'b1011, 4'b0100, 1'b1, lat, bcnt, ovl);
        chk_cnt++;
        if ({Co, S} !== exp || lat != 4) begin
            err_cnt++;
            $display("FAIL midrun_fresh got Co=%b S=%b lat=%0d exp Co=%b S=%b lat=4", Co, S, lat, exp[4], exp[3:0]);
        end
        step();
    endtask

    task automatic test_exhaustive();
        int lat, bcnt;
        logic ovl;
        logic [4:0] exp;
        logic [8:0] v;
        for (int i = 0; i < 512; i++) begin
            v   = 9'(i);
            exp = ref_op(v[3:0], v[7:4], v[8]);
            do_op(v[3:0], v[7:4], v[8], lat, bcnt, ovl);
            chk_cnt++;
            if ({Co, S} !== exp || lat != 4 || bcnt != 4 || ovl) begin
                err_cnt++;
                $display("FAIL exh A=%b B=%b Ci=%b got Co=%b S=%b lat=%0d busy=%0d exp Co=%b S=%b lat=4 busy=4",
                         v[3:0], v[7:4], v[8], Co, S, lat, bcnt, exp[4], exp[3:0]);
            end
        end
        step();
    endtask

    task automatic test_random();
        int lat, bcnt;
        logic ovl;
        logic [3:0] a, b;
        logic ci;
        logic [4:0] exp;
        for (int i = 0; i < 60; i++) begin
            a = 4'($urandom); b = 4'($urandom); ci = 1'($urandom);
            exp = ref_op(a, b, ci);
            do_op(a, b, ci, lat, bcnt, ovl);
            chk_cnt++;
            if ({Co, S} !== exp || lat != 4 || ovl) begin
                err_cnt++;
                $display("FAIL rand A=%b B=%b Ci=%b got Co=%b S=%b lat=%0d exp Co=%b S=%b lat=4",
                         a, b, ci, Co, S, lat, exp[4], exp[3:0]);
            end
            // a random gap of zero cycles exercises back-to-back issue from DONE
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) step();
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_run();
        test_exhaustive();
        test_random();
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adder_sub_4bit_serial.md
# adder_sub_4bit_serial

Bit-serial, multi-cycle counterpart of the combinational 4-bit adder/subtractor. It takes the same parallel operands and mode bit, A, B and Ci, through a start/done handshake. It computes the result one bit per clock using a single full-adder slice and a stored carry, then returns S and Co. It is used where datapath area matters more than latency, and its results must match the combinational block bit-for-bit.

## Interface
- WIDTH, default 4, operand/result width; the cycle count scales with it. All values below assume 4.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request. Sampled only when busy=0.
- A  input  4  operand A. Captured on the accepted start.
- B  input  4  operand B. Captured on the accepted start.
- Ci  input  1  mode. 0 = add (A+B); 1 = subtract (A+~B+1). Captured on the accepted start.
- S  output  4  result. Registered and held until the next completion.
- Co  output  1  carry out. In subtract mode, Co=1 means no borrow (A>=B unsigned).
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when S/Co update.

## Operation
- **States:**
  - IDLE: waits for start.
  - RUN: shifts for WIDTH cycles.
  - DONE: one cycle, pulses done.
- **Accept:** start=1 in IDLE or DONE at a rising edge performs the following:
  - latches A into shift register a_sr.
  - latches B, or ~B when Ci=1, into b_sr.
  - initialises the carry register to Ci.
  - clears the bit counter and the result shift register.
  - enters RUN.
- **RUN, each cycle:**
  - sum = a_sr[0]^b_sr[0]^c.
  - c <= majority(a_sr[0], b_sr[0], c).
  - the sum bit is shifted into the MSB of the result shift register.
  - a_sr and b_sr shift right.
  - the counter increments.
- **RUN exit:** after the WIDTH-th bit, on the same edge:
  - S <= completed result.
  - Co <= final carry.
  - the FSM goes to DONE.
- **DONE:** done=1 and busy=0.
  - Next state is RUN if start=1, otherwise IDLE.
- **Result definition:**
  - {Co,S} = A + (Ci ? ~B : B) + Ci, computed in WIDTH+1 bits. This is identical to the combinational block.
- **start while busy=1:** ignored. Captured registers are unaffected, and A/B/Ci may change freely during RUN.
- **Reset**, including mid-RUN:
  - aborts the operation and forces IDLE.
  - S=0, Co=0, busy=0, done=0.
  - internal registers are cleared and no done is issued.
  - rst has priority over start in the same cycle.
- **S/Co between operations:** keep the last completed result. They never show partial sums.

## Timing
- start is sampled at edge k. busy is high from after edge k through edge k+WIDTH, i.e. 4 cycles.
- S/Co are valid, and done=1, in the cycle after edge k+WIDTH (k+4). Latency is start-edge to done = WIDTH cycles.
- done is a single-cycle pulse. busy and done are never high together.
- Back-to-back operation: start held high during the DONE cycle begins the next operation with no idle cycle. Throughput is one result per WIDTH+1 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset values: S=4'b0000, Co=0, busy=0, done=0. Reset acts at the first rising edge with rst=1.

## Test plan
- **Add:** A=0110, B=1001, Ci=0, start pulse. Required response:
  - busy high for 4 cycles.
  - done pulse 4 cycles after start.
  - S=1111, Co=0.
- **Subtract with borrow:** A=0110, B=1001, Ci=1 -> S=1101, Co=0.
- **Subtract with no borrow:** A=0110, B=0110, Ci=1 -> S=0000, Co=1.
- **Zero subtract:** A=0000, B=0000, Ci=1 -> S=0000, Co=1.
- **Ignored and back-to-back starts:**
  - Start A=0110, B=1111, Ci=0.
  - Toggle start and change A/B during busy. The first result must be S=0101, Co=1.
  - Hold start=1 in DONE with A=0000, B=1001, Ci=1. This must produce S=0111, Co=0 exactly 5 cycles after the first done.
- **Reset mid-RUN:** assert rst for 1 cycle at the 2nd RUN cycle. Required response:
  - the next cycle shows busy=0, done=0, S=0000, Co=0.
  - no done pulse follows.
  - a fresh operation afterwards completes correctly.
- **Exhaustive check:** all 512 combinations of A, B and Ci are compared against the combinational reference formula.
